// File: rtl/sd_read_sequencer.sv
// Resets an sd_file_reader, releases it and watches for progress, retrying on a stall.
// Reports done/fail pulses, an error code, the attempt number and a byte count.
module sd_read_sequencer #(
  parameter int         RST_HOLD_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES  = 100000000,
  parameter int         MAX_ATTEMPTS    = 3,
  parameter logic [2:0] DONE_STATE      = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        rdr_rst_n,
  input  logic [2:0]  fatstate,
  input  logic        file_found,
  input  logic        outreq,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [1:0]  err_code,
  output logic [31:0] byte_count,
  output logic [3:0]  attempt,
  output logic [1:0]  seq_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [3:0]    ATT_MAX    = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_KEEP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    attempt_q, attempt_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   bc_q, bc_d;
  logic [2:0]    prev_q, prev_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          rdr_rst_n_q, rdr_rst_n_d;
  logic          busy_q, busy_d;
  logic          begin_seq;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    attempt_d = attempt_q;
    err_d     = err_q;
    bc_d      = bc_q;
    prev_d    = fatstate;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    begin_seq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin_seq = 1'b1;
      end
      S_KEEP: begin
        if (abort)      state_d = S_IDLE;
        else if (start) begin_seq = 1'b1;
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
          err_d   = 2'd3;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        // Bytes are counted even in the cycle that ends the run.
        if (outreq && (bc_q != 32'hFFFF_FFFF)) bc_d = bc_q + 32'd1;
        if (abort) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
          err_d   = 2'd3;
        end else if ((fatstate == DONE_STATE) && file_found) begin
          state_d = S_KEEP;
          done_d  = 1'b1;
        end else if (fatstate == DONE_STATE) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
          err_d   = 2'd1;
        end else if (outreq || (fatstate != prev_q)) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          if (attempt_q < ATT_MAX) begin
            state_d   = S_HOLD;
            attempt_d = attempt_q + 4'd1;
            bc_d      = '0;
            hold_d    = '0;
          end else begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
            err_d   = 2'd2;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_seq) begin
      state_d   = S_HOLD;
      attempt_d = 4'd1;
      err_d     = 2'd0;
      bc_d      = '0;
      hold_d    = '0;
    end

    // Reader stays out of reset in KEEP so its status outputs remain meaningful.
    rdr_rst_n_d = (state_d == S_RUN) || (state_d == S_KEEP);
    busy_d      = (state_d == S_HOLD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      timer_q     <= '0;
      attempt_q   <= '0;
      err_q       <= '0;
      bc_q        <= '0;
      prev_q      <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      rdr_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      attempt_q   <= attempt_d;
      err_q       <= err_d;
      bc_q        <= bc_d;
      prev_q      <= prev_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      rdr_rst_n_q <= rdr_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign rdr_rst_n  = rdr_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign err_code   = err_q;
  assign byte_count = bc_q;
  assign attempt    = attempt_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Bench for sd_read_sequencer: a scripted reader model with random byte timing,
// expected outcomes computed from the sequencing rules.
module tb_sd_read_sequencer;
  localparam int HOLD = 4;
  localparam int TO   = 64;
  localparam int MAXA = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, file_found, outreq;
  logic [2:0]  fatstate;
  logic        rdr_rst_n, busy, done, fail;
  logic [1:0]  err_code, seq_state;
  logic [31:0] byte_count;
  logic [3:0]  attempt;

  int pass_cnt = 0;
  int total_cnt = 0;

  sd_read_sequencer #(
    .RST_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .MAX_ATTEMPTS(MAXA), .DONE_STATE(3'd6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rdr_rst_n(rdr_rst_n),
    .fatstate(fatstate), .file_found(file_found), .outreq(outreq), .busy(busy),
    .done(done), .fail(fail), .err_code(err_code), .byte_count(byte_count),
    .attempt(attempt), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts consecutive observed cycles spent in state s (bounded); ok drops if rdr_rst_n deviates.
  task automatic count_state(input logic [1:0] s, input logic exp_rn, output int n, output bit ok);
    n = 0;
    ok = 1'b1;
    while (seq_state == s && n < 1000) begin
      if (rdr_rst_n !== exp_rn) ok = 1'b0;
      n++;
      tick();
    end
  endtask

  task automatic launch(output int hold_n, output bit ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    count_state(2'd1, 1'b0, hold_n, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; fatstate = 0; file_found = 0; outreq = 0;
    repeat (3) tick();
    total_cnt++; if (rdr_rst_n !== 1'b0) $display("FAIL reset_rdr_rst_n got=%b exp=0", rdr_rst_n); else pass_cnt++;
    total_cnt++; if (seq_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", seq_state); else pass_cnt++;
    total_cnt++; if ({busy, done, fail} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, done, fail}); else pass_cnt++;
    total_cnt++; if ({err_code, attempt} !== 6'd0 || byte_count !== 32'd0)
      $display("FAIL reset_regs got err=%0d att=%0d bytes=%0d exp 0/0/0", err_code, attempt, byte_count); else pass_cnt++;
    rst = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    total_cnt++; if (seq_state !== 2'd0 || fail !== 1'b0) $display("FAIL idle_abort_ignored got state=%0d fail=%b exp 0/0", seq_state, fail); else pass_cnt++;
  endtask

  task automatic test_normal(input int n_pulses);
    int  h;
    bit  ok;
    bit  sched[20];
    int  placed, extra, exp_bytes;
    fatstate = 3'd0; file_found = 1'b0;
    foreach (sched[i]) sched[i] = 1'b0;
    placed = 0;
    while (placed < n_pulses) begin
      int p = $urandom_range(0, 18);
      if (!sched[p]) begin sched[p] = 1'b1; placed++; end
    end
    extra = $urandom_range(0, 1);
    exp_bytes = n_pulses + extra;
    launch(h, ok);
    total_cnt++; if (h !== HOLD || !ok) $display("FAIL normal_hold got=%0d ok=%b exp=%0d", h, ok, HOLD); else pass_cnt++;
    total_cnt++; if (seq_state !== 2'd2 || rdr_rst_n !== 1'b1) $display("FAIL normal_run_entry got state=%0d rn=%b exp 2/1", seq_state, rdr_rst_n); else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      outreq = sched[c] || (c == 19 && extra == 1);
      if (c == 19) begin fatstate = 3'd6; file_found = 1'b1; end
      tick();
    end
    outreq = 1'b0;
    total_cnt++; if (done !== 1'b1 || fail !== 1'b0) $display("FAIL normal_done_pulse got done=%b fail=%b exp 1/0", done, fail); else pass_cnt++;
    total_cnt++; if (byte_count !== exp_bytes) $display("FAIL normal_byte_count got=%0d exp=%0d", byte_count, exp_bytes); else pass_cnt++;
    total_cnt++; if (attempt !== 4'd1 || err_code !== 2'd0) $display("FAIL normal_att_err got att=%0d err=%0d exp 1/0", attempt, err_code); else pass_cnt++;
    total_cnt++; if (seq_state !== 2'd3 || rdr_rst_n !== 1'b1 || busy !== 1'b0)
      $display("FAIL normal_keep got state=%0d rn=%b busy=%b exp 3/1/0", seq_state, rdr_rst_n, busy); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL normal_done_width got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_frozen();
    int h, r;
    bit ok;
    fatstate = 3'($urandom_range(0, 5)); file_found = $urandom_range(0, 1);
    launch(h, ok);
    total_cnt++; if (h !== HOLD || !ok) $display("FAIL frozen_hold1 got=%0d ok=%b exp=%0d", h, ok, HOLD); else pass_cnt++;
    for (int a = 1; a <= MAXA; a++) begin
      total_cnt++; if (attempt !== 4'(a)) $display("FAIL frozen_attempt got=%0d exp=%0d", attempt, a); else pass_cnt++;
      count_state(2'd2, 1'b1, r, ok);
      total_cnt++; if (r !== TO || !ok) $display("FAIL frozen_run_len got=%0d ok=%b exp=%0d", r, ok, TO); else pass_cnt++;
      if (a < MAXA) begin
        total_cnt++; if (attempt !== 4'(a + 1) || byte_count !== 32'd0) $display("FAIL frozen_retry got att=%0d bytes=%0d exp %0d/0", attempt, byte_count, a + 1); else pass_cnt++;
        count_state(2'd1, 1'b0, h, ok);
        total_cnt++; if (h !== HOLD || !ok) $display("FAIL frozen_hold got=%0d ok=%b exp=%0d", h, ok, HOLD); else pass_cnt++;
      end
    end
    total_cnt++; if (fail !== 1'b1 || done !== 1'b0 || err_code !== 2'd2)
      $display("FAIL frozen_fail got fail=%b done=%b err=%0d exp 1/0/2", fail, done, err_code); else pass_cnt++;
    total_cnt++; if (attempt !== 4'(MAXA) || seq_state !== 2'd0 || rdr_rst_n !== 1'b0)
      $display("FAIL frozen_final got att=%0d state=%0d rn=%b exp %0d/0/0", attempt, seq_state, rdr_rst_n, MAXA); else pass_cnt++;
    tick();
    total_cnt++; if (fail !== 1'b0) $display("FAIL frozen_fail_width got=%b exp=0", fail); else pass_cnt++;
  endtask

  task automatic test_not_found();
    int h;
    bit ok;
    fatstate = 3'd0; file_found = 1'b0;
    launch(h, ok);
    repeat ($urandom_range(1, 10)) tick();
    fatstate = 3'd6;
    tick();
    total_cnt++; if (fail !== 1'b1 || err_code !== 2'd1 || attempt !== 4'd1)
      $display("FAIL notfound_fail got fail=%b err=%0d att=%0d exp 1/1/1", fail, err_code, attempt); else pass_cnt++;
    total_cnt++; if (rdr_rst_n !== 1'b0 || seq_state !== 2'd0 || busy !== 1'b0)
      $display("FAIL notfound_idle got rn=%b state=%0d busy=%b exp 0/0/0", rdr_rst_n, seq_state, busy); else pass_cnt++;
    fatstate = 3'd0;
    tick();
    total_cnt++; if (seq_state !== 2'd0 || fail !== 1'b0) $display("FAIL notfound_no_retry got state=%0d fail=%b exp 0/0", seq_state, fail); else pass_cnt++;
  endtask

  task automatic test_abort();
    int h, cnt;
    bit ok;
    fatstate = 3'd2; file_found = 1'b0;
    launch(h, ok);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      outreq = (c == 9) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c == 9) abort = 1'b1;
      if (outreq) cnt++;
      tick();
    end
    outreq = 1'b0; abort = 1'b0;
    total_cnt++; if (fail !== 1'b1 || err_code !== 2'd3 || seq_state !== 2'd0)
      $display("FAIL abort_fail got fail=%b err=%0d state=%0d exp 1/3/0", fail, err_code, seq_state); else pass_cnt++;
    total_cnt++; if (byte_count !== cnt) $display("FAIL abort_bytes got=%0d exp=%0d", byte_count, cnt); else pass_cnt++;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total_cnt++; if (seq_state !== 2'd0 || busy !== 1'b0 || err_code !== 2'd3)
      $display("FAIL start_abort_idle got state=%0d busy=%b err=%0d exp 0/0/3", seq_state, busy, err_code); else pass_cnt++;
    tick();
    total_cnt++; if (seq_state !== 2'd0 || fail !== 1'b0) $display("FAIL start_abort_stays got state=%0d fail=%b exp 0/0", seq_state, fail); else pass_cnt++;
  endtask

  task automatic test_progress();
    int h, cnt, next, bad;
    bit ok;
    fatstate = 3'd1; file_found = 1'b0;
    launch(h, ok);
    cnt = 0; bad = 0;
    next = $urandom_range(20, 60);
    for (int c = 1; c <= 500; c++) begin
      if (seq_state !== 2'd2 || attempt !== 4'd1) bad++;
      outreq = (c == next);
      if (outreq) begin cnt++; next = c + $urandom_range(20, 60); end
      start = (c == 200);
      tick();
    end
    outreq = 1'b0; start = 1'b0;
    total_cnt++; if (bad !== 0) $display("FAIL progress_no_timeout got bad_cycles=%0d exp=0", bad); else pass_cnt++;
    total_cnt++; if (byte_count !== cnt) $display("FAIL progress_bytes got=%0d exp=%0d", byte_count, cnt); else pass_cnt++;
    fatstate = 3'd6; file_found = 1'b1;
    tick();
    total_cnt++; if (done !== 1'b1 || attempt !== 4'd1 || seq_state !== 2'd3)
      $display("FAIL progress_done got done=%b att=%0d state=%0d exp 1/1/3", done, attempt, seq_state); else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if (seq_state !== 2'd0 || done !== 1'b0 || fail !== 1'b0 || err_code !== 2'd0)
      $display("FAIL keep_abort got state=%0d done=%b fail=%b err=%0d exp 0/0/0/0", seq_state, done, fail, err_code); else pass_cnt++;
    total_cnt++; if (rdr_rst_n !== 1'b0 || byte_count !== cnt)
      $display("FAIL keep_abort_hold got rn=%b bytes=%0d exp 0/%0d", rdr_rst_n, byte_count, cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int h;
    bit ok;
    fatstate = 3'd0; file_found = 1'b0;
    launch(h, ok);
    outreq = 1'b1;
    repeat (5) tick();
    outreq = 1'b0;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (rdr_rst_n !== 1'b0 || busy !== 1'b0 || seq_state !== 2'd0)
      $display("FAIL async_rst_ctrl got rn=%b busy=%b state=%0d exp 0/0/0", rdr_rst_n, busy, seq_state); else pass_cnt++;
    total_cnt++; if (byte_count !== 32'd0 || attempt !== 4'd0 || err_code !== 2'd0 || {done, fail} !== 2'b00)
      $display("FAIL async_rst_regs got bytes=%0d att=%0d err=%0d df=%b exp 0", byte_count, attempt, err_code, {done, fail}); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    launch(h, ok);
    total_cnt++; if (h !== HOLD || !ok || seq_state !== 2'd2 || attempt !== 4'd1)
      $display("FAIL post_rst_seq got hold=%0d ok=%b state=%0d att=%0d exp %0d/1/2/1", h, ok, seq_state, attempt, HOLD); else pass_cnt++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_normal(5);
    for (int i = 0; i < 3; i++) test_normal($urandom_range(0, 12));
    test_frozen();
    test_not_found();
    test_abort();
    test_progress();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
